uci_host: RTL and testbench
===========================

// Module: uci_host
// PURPOSE
//  GUI-side UCI initiator: drives a UCI engine (e.g. uci_handler) over a byte stream. After reset it sends
//  "uci\n" and waits for "uciok". It keeps a move history and on request sends "position startpos[ moves ...]\n"
//  then "go\n". It parses the engine's reply lines, returns the decoded "bestmove", and appends that move to the history.
// PARAMETERS
//  MAX_PLY   256  history depth, in moves; PW = $clog2(MAX_PLY+1)
//  LINE_LEN  16   RX line buffer, in chars; characters past LINE_LEN are dropped (the line itself is still parsed)
// PORTS
//  clk_in              in   1     clock
//  rst_in              in   1     synchronous reset, active-low
//  move_in             in   move_t move to append (opponent/GUI move)
//  move_in_valid       in   1     valid/ready
//  move_in_ready       out  1
//  new_game_in         in   1     pulse: clear history
//  go_in_valid         in   1     request a search
//  go_in_ready         out  1
//  char_out            out  8     TX byte to engine
//  char_out_valid      out  1     valid/ready
//  char_out_ready      in   1
//  char_in             in   8     RX byte from engine
//  char_in_valid       in   1
//  char_in_ready       out  1     constant 1
//  best_move_out       out  move_t decoded best move
//  best_move_out_valid out  1     valid/ready
//  best_move_out_ready in   1
//  uci_ok_out          out  1     sticky: "uciok" received
//  ply_out             out  PW    number of stored moves
//  busy_out            out  1     TX FSM not in IDLE
// BEHAVIOUR
//  Reset (rst_in==0, sync): history cleared; ply_out=0; all valid outputs=0; uci_ok_out=0; RX buffer cleared; TX->SEND_UCI.
//  Move char encoding: "a"+col, "1"+row, for src then dst. Promotion char n/b/r/q maps to SPECIAL_PROMOTE_*; else SPECIAL_NONE.
//  TX handshake: char_out/char_out_valid registered. A byte is held stable while valid&&!ready. One byte advances per accepted beat.
//  TX FSM:
//   SEND_UCI: "uci\n" -> WAIT_OK.
//   WAIT_OK: -> IDLE when uci_ok_out rises.
//   IDLE: go_in_ready=1 and move_in_ready=(ply_out<MAX_PLY). Priority: new_game_in > move_in > go_in.
//    new_game_in clears ply_out; it is ignored outside IDLE. move_in stores move at index ply_out, then ply_out++.
//    go_in accepted -> POS.
//   POS: "position startpos". If ply_out==0 -> NL; else -> MOVES_KW.
//   MOVES_KW: " moves" -> MOVE, with index=0.
//   MOVE: emits ' ', then 4 chars, plus the promotion char if present; index++. When index==ply_out -> NL.
//   NL: "\n" -> GO.
//   GO: "go\n" -> WAIT_BM.
//   WAIT_BM: waits for a decoded bestmove, then -> RESULT.
//   RESULT: best_move_out_valid=1, held until ready. On handshake: append the move if ply_out<MAX_PLY (else dropped). -> IDLE.
//  move_in_ready and go_in_ready are 0 outside IDLE; no queuing.
//  RX: chars are appended to the line buffer. '\r' is ignored. On '\n' the line is matched, then the buffer is cleared:
//   "uciok" (exact) -> uci_ok_out=1, in any state.
//   "bestmove " + 4 chars (+optional n/b/r/q, optionally followed by ' ...'):
//    - Decoded only in WAIT_BM.
//    - Accepted only if files are in a..h and ranks in 1..8; otherwise discarded (e.g. "(none)") and the FSM stays in WAIT_BM.
//   Every other line ("info ...", "id ...", "readyok") is discarded.
//  The RX path is independent of TX; reception during TX is allowed. A bestmove received outside WAIT_BM is discarded.
//  Output latency: bestmove '\n' accepted at cycle N -> best_move_out_valid=1 at N+1.
//  Reset mid-operation: any partial TX line or RX line is abandoned, and the next TX stream begins with "uci\n".
// TESTING
//  1. Reset release, char_out_ready=1 -> bytes "uci\n". Feed "id name x\nuciok\n" -> uci_ok_out=1; busy_out=0.
//  2. ply 0, go_in -> exactly "position startpos\ngo\n"; go_in_ready=0 until bestmove returns.
//  3. Append e2e4 and g8f6. go -> "position startpos moves e2e4 g8f6\ngo\n".
//     Feed "info depth 3\nbestmove d2d4\n" -> move (3,1)->(3,3) SPECIAL_NONE; ply_out=3 after handshake.
//  4. "bestmove e7e8q\n" -> special=SPECIAL_PROMOTE_QUEEN. Next position line contains " e7e8q".
//  5. char_out_ready toggling randomly -> byte stream identical to ready=1; no byte is dropped or duplicated.
//  6. Fill to MAX_PLY -> move_in_ready=0. Feed "bestmove (none)\n" in WAIT_BM -> no output.
//     rst_in=0 mid-"position" -> the stream restarts with "uci\n" and ply_out=0.

Source files
------------

// File: rtl/uci_host_if.sv
// uci_host_if: GUI and engine facing signal bundle of uci_host (move/go requests,
// TX/RX byte streams, decoded best move and status).
interface uci_host_if #(
   parameter int unsigned MAX_PLY = 256
);
   localparam int unsigned PW = $clog2(MAX_PLY + 1);

   // Board squares as (col,row) 0..7; special carries the promotion piece.
   typedef struct packed {
      logic [2:0] src_col;
      logic [2:0] src_row;
      logic [2:0] dst_col;
      logic [2:0] dst_row;
      logic [2:0] special;
   } move_t;

   move_t         move_in;
   logic          move_in_valid;
   logic          move_in_ready;
   logic          new_game_in;
   logic          go_in_valid;
   logic          go_in_ready;
   logic [7:0]    char_out;
   logic          char_out_valid;
   logic          char_out_ready;
   logic [7:0]    char_in;
   logic          char_in_valid;
   logic          char_in_ready;
   move_t         best_move_out;
   logic          best_move_out_valid;
   logic          best_move_out_ready;
   logic          uci_ok_out;
   logic [PW-1:0] ply_out;
   logic          busy_out;

   modport master (
      input  move_in, move_in_valid, new_game_in, go_in_valid,
             char_out_ready, char_in, char_in_valid, best_move_out_ready,
      output move_in_ready, go_in_ready, char_out, char_out_valid, char_in_ready,
             best_move_out, best_move_out_valid, uci_ok_out, ply_out, busy_out
   );

   modport slave (
      output move_in, move_in_valid, new_game_in, go_in_valid,
             char_out_ready, char_in, char_in_valid, best_move_out_ready,
      input  move_in_ready, go_in_ready, char_out, char_out_valid, char_in_ready,
             best_move_out, best_move_out_valid, uci_ok_out, ply_out, busy_out
   );
endinterface

// File: rtl/uci_host.sv
// uci_host: GUI-side UCI initiator. Handshakes "uci"/"uciok", keeps the move
// history, emits "position startpos[ moves ...]" + "go", and decodes "bestmove".
// LINE_LEN must be at least 15 so the promotion char and its separator are kept.
module uci_host #(
   parameter int unsigned MAX_PLY  = 256,
   parameter int unsigned LINE_LEN = 16
) (
   input logic        clk_in,
   input logic        rst_in,
   uci_host_if.master bus
);
   localparam int unsigned PW = $clog2(MAX_PLY + 1);
   localparam int unsigned IW = (MAX_PLY > 1) ? $clog2(MAX_PLY) : 1;
   localparam int unsigned LW = $clog2(LINE_LEN + 1);
   localparam int unsigned BW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;

   localparam logic [2:0] SPECIAL_NONE          = 3'd0;
   localparam logic [2:0] SPECIAL_PROMOTE_KNIGHT = 3'd1;
   localparam logic [2:0] SPECIAL_PROMOTE_BISHOP = 3'd2;
   localparam logic [2:0] SPECIAL_PROMOTE_ROOK   = 3'd3;
   localparam logic [2:0] SPECIAL_PROMOTE_QUEEN  = 3'd4;

   // Fixed TX text, addressed directly by the sequencer.
   localparam logic [4:0] A_UCI = 5'd0,  A_UCI_END = 5'd3;
   localparam logic [4:0] A_POS = 5'd4,  A_POS_END = 5'd20;
   localparam logic [4:0] A_MVS = 5'd21, A_MVS_END = 5'd26;
   localparam logic [4:0] A_NL  = 5'd27;
   localparam logic [4:0] A_GO  = 5'd28, A_GO_END  = 5'd30;
   localparam logic [7:0] ROM [32] = '{
      "u", "c", "i", "\n",
      "p", "o", "s", "i", "t", "i", "o", "n", " ", "s", "t", "a", "r", "t", "p", "o", "s",
      " ", "m", "o", "v", "e", "s",
      "\n",
      "g", "o", "\n",
      8'h00
   };

   typedef enum logic [3:0] {
      SEND_UCI, WAIT_OK, IDLE, POS, MOVES_KW, MOVE, NL, GO, WAIT_BM, RESULT
   } state_t;

   state_t        state;
   logic [4:0]    addr;
   logic [PW-1:0] ply, mv_idx;
   logic [2:0]    mv_sub;
   logic [7:0]    co;
   logic          cov;
   logic [14:0]   bm_q;
   logic          bmv;
   logic          uci_ok;
   logic [14:0]   hist [MAX_PLY];
   logic [7:0]    rx_buf [LINE_LEN];
   logic [LW-1:0] rx_len;

   logic          tx_free, room, move_acc, go_acc;
   logic [14:0]   hm;
   logic [7:0]    mv_byte;
   logic          mv_last;
   logic          line_uciok, bm_kw, bm_sq, bm_ok, bm_line;
   logic [2:0]    bm_promo, bm_special;
   logic [14:0]   bm_dec;

   function automatic logic is_file(input logic [7:0] c);
      return (c >= "a") && (c <= "h");
   endfunction

   function automatic logic is_rank(input logic [7:0] c);
      return (c >= "1") && (c <= "8");
   endfunction

   function automatic logic [2:0] promo_of(input logic [7:0] c);
      case (c)
         "n":     return SPECIAL_PROMOTE_KNIGHT;
         "b":     return SPECIAL_PROMOTE_BISHOP;
         "r":     return SPECIAL_PROMOTE_ROOK;
         "q":     return SPECIAL_PROMOTE_QUEEN;
         default: return SPECIAL_NONE;
      endcase
   endfunction

   // new_game_in outranks move_in, which outranks go_in; readies are masked so
   // a request never sees ready while a higher-priority one is taken instead.
   assign tx_free  = !cov || bus.char_out_ready;
   assign room     = ply < PW'(MAX_PLY);
   assign move_acc = (state == IDLE) && !bus.new_game_in && bus.move_in_valid && room;
   assign go_acc   = (state == IDLE) && !bus.new_game_in && !move_acc && bus.go_in_valid;

   assign bus.move_in_ready       = (state == IDLE) && room && !bus.new_game_in;
   assign bus.go_in_ready         = (state == IDLE) && !bus.new_game_in && !(bus.move_in_valid && room);
   assign bus.char_out            = co;
   assign bus.char_out_valid      = cov;
   assign bus.char_in_ready       = 1'b1;
   assign bus.best_move_out       = bm_q;
   assign bus.best_move_out_valid = bmv;
   assign bus.uci_ok_out          = uci_ok;
   assign bus.ply_out             = ply;
   assign bus.busy_out            = (state != IDLE);

   // Text of one history move: ' ', src, dst, optional promotion char
   always_comb begin
      hm      = hist[mv_idx[IW-1:0]];
      mv_byte = " ";
      mv_last = 1'b0;
      case (mv_sub)
         3'd1: mv_byte = 8'h61 + {5'd0, hm[14:12]};
         3'd2: mv_byte = 8'h31 + {5'd0, hm[11:9]};
         3'd3: mv_byte = 8'h61 + {5'd0, hm[8:6]};
         3'd4: begin
            mv_byte = 8'h31 + {5'd0, hm[5:3]};
            mv_last = (hm[2:0] == SPECIAL_NONE);
         end
         3'd5: begin
            mv_last = 1'b1;
            case (hm[2:0])
               SPECIAL_PROMOTE_KNIGHT: mv_byte = "n";
               SPECIAL_PROMOTE_BISHOP: mv_byte = "b";
               SPECIAL_PROMOTE_ROOK:   mv_byte = "r";
               default:                mv_byte = "q";
            endcase
         end
         default: mv_byte = " ";
      endcase
   end

   // Match the buffered line; "a".."h" and "1".."8" both sit at low bits 1..8 mod 8,
   // so subtracting 1 from the low three bits yields the 0..7 coordinate.
   always_comb begin
      line_uciok = (rx_len == LW'(5)) &&
                   ({rx_buf[0], rx_buf[1], rx_buf[2], rx_buf[3], rx_buf[4]} == "uciok");
      bm_kw      = {rx_buf[0], rx_buf[1], rx_buf[2], rx_buf[3], rx_buf[4],
                    rx_buf[5], rx_buf[6], rx_buf[7], rx_buf[8]} == "bestmove ";
      bm_sq      = is_file(rx_buf[9]) && is_rank(rx_buf[10]) &&
                   is_file(rx_buf[11]) && is_rank(rx_buf[12]);
      bm_promo   = promo_of(rx_buf[13]);
      bm_ok      = 1'b0;
      bm_special = SPECIAL_NONE;
      if ((rx_len >= LW'(13)) && bm_kw && bm_sq) begin
         if ((rx_len == LW'(13)) || (rx_buf[13] == " ")) begin
            bm_ok = 1'b1;
         end else if ((bm_promo != SPECIAL_NONE) &&
                      ((rx_len == LW'(14)) || (rx_buf[14] == " "))) begin
            bm_ok      = 1'b1;
            bm_special = bm_promo;
         end
      end
      bm_dec  = {rx_buf[9][2:0] - 3'd1, rx_buf[10][2:0] - 3'd1,
                 rx_buf[11][2:0] - 3'd1, rx_buf[12][2:0] - 3'd1, bm_special};
      bm_line = bus.char_in_valid && (bus.char_in == "\n") && bm_ok;
   end

   // RX line assembly and sticky uciok detection
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         rx_len <= '0;
         uci_ok <= 1'b0;
      end else if (bus.char_in_valid) begin
         if (bus.char_in == "\n") begin
            if (line_uciok) uci_ok <= 1'b1;
            rx_len <= '0;
         end else if ((bus.char_in != "\r") && (rx_len < LW'(LINE_LEN))) begin
            rx_buf[rx_len[BW-1:0]] <= bus.char_in;
            rx_len <= rx_len + LW'(1);
         end
      end
   end

   // Move history storage: GUI moves and accepted engine moves
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         if (move_acc)
            hist[ply[IW-1:0]] <= bus.move_in;
         else if ((state == RESULT) && bus.best_move_out_ready && room)
            hist[ply[IW-1:0]] <= bm_q;
      end
   end

   // TX sequencer, ply counter and best-move result register
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state  <= SEND_UCI;
         addr   <= A_UCI;
         ply    <= '0;
         mv_idx <= '0;
         mv_sub <= '0;
         co     <= '0;
         cov    <= 1'b0;
         bm_q   <= '0;
         bmv    <= 1'b0;
      end else begin
         if (cov && bus.char_out_ready) cov <= 1'b0;
         case (state)
            SEND_UCI: if (tx_free) begin
               co <= ROM[addr]; cov <= 1'b1;
               if (addr == A_UCI_END) state <= WAIT_OK;
               else addr <= addr + 5'd1;
            end
            WAIT_OK: if (uci_ok) state <= IDLE;
            IDLE: begin
               if (bus.new_game_in) ply <= '0;
               else if (move_acc) ply <= ply + PW'(1);
               else if (go_acc) begin
                  state <= POS;
                  addr  <= A_POS;
               end
            end
            POS: if (tx_free) begin
               co <= ROM[addr]; cov <= 1'b1;
               if (addr != A_POS_END) addr <= addr + 5'd1;
               else if (ply == '0) begin
                  state <= NL;
                  addr  <= A_NL;
               end else begin
                  state <= MOVES_KW;
                  addr  <= A_MVS;
               end
            end
            MOVES_KW: if (tx_free) begin
               co <= ROM[addr]; cov <= 1'b1;
               if (addr == A_MVS_END) begin
                  state  <= MOVE;
                  mv_idx <= '0;
                  mv_sub <= '0;
               end else addr <= addr + 5'd1;
            end
            MOVE: if (tx_free) begin
               co <= mv_byte; cov <= 1'b1;
               if (mv_last) begin
                  mv_sub <= '0;
                  mv_idx <= mv_idx + PW'(1);
                  if (mv_idx + PW'(1) == ply) begin
                     state <= NL;
                     addr  <= A_NL;
                  end
               end else mv_sub <= mv_sub + 3'd1;
            end
            NL: if (tx_free) begin
               co <= ROM[addr]; cov <= 1'b1;
               state <= GO;
               addr  <= A_GO;
            end
            GO: if (tx_free) begin
               co <= ROM[addr]; cov <= 1'b1;
               if (addr == A_GO_END) state <= WAIT_BM;
               else addr <= addr + 5'd1;
            end
            WAIT_BM: if (bm_line) begin
               bm_q  <= bm_dec;
               bmv   <= 1'b1;
               state <= RESULT;
            end
            RESULT: if (bus.best_move_out_ready) begin
               bmv   <= 1'b0;
               state <= IDLE;
               if (room) ply <= ply + PW'(1);
            end
            default: state <= SEND_UCI;
         endcase
      end
   end
endmodule

// File: tb/tb_uci_host.sv
// tb_uci_host: directed bench for uci_host with a 4-move history.
module tb_uci_host;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;
   logic rand_rdy = 1'b0;

   byte unsigned txq [$];
   logic         pend = 1'b0;
   logic [7:0]   pend_byte = '0;
   logic [14:0]  bm_vec;

   uci_host_if #(.MAX_PLY(4)) bus();

   uci_host #(.MAX_PLY(4), .LINE_LEN(16)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus.master)
   );

   assign bm_vec = bus.best_move_out;

   always #5 clk = ~clk;

   // Engine-side ready: steady 1, or a coin flip per cycle when rand_rdy is set
   always @(posedge clk) begin
      #1;
      bus.char_out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Capture accepted TX bytes; a stalled byte must stay put until taken
   always @(negedge clk) begin
      if (!rst) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            total++;
            assert (bus.char_out_valid === 1'b1 && bus.char_out === pend_byte) else begin
               bad++;
               $error("FAIL tx_hold: observed valid=%0b byte=%0h expected valid=1 byte=%0h",
                      bus.char_out_valid, bus.char_out, pend_byte);
            end
         end
         if (bus.char_out_valid && bus.char_out_ready) txq.push_back(bus.char_out);
         pend      = bus.char_out_valid && !bus.char_out_ready;
         pend_byte = bus.char_out;
      end
   end

   function automatic logic [14:0] mk(input int sc, input int sr, input int dc, input int dr, input int sp);
      return {3'(sc), 3'(sr), 3'(dc), 3'(dr), 3'(sp)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_tx(input string tag, input string exp);
      string       got;
      int unsigned n;
      got = "";
      n   = 0;
      while (txq.size() < exp.len() && n < 3000) begin
         @(negedge clk);
         n++;
      end
      while (txq.size() > 0 && got.len() < exp.len()) got = $sformatf("%s%c", got, txq.pop_front());
      total++;
      assert (got == exp) else begin
         bad++;
         $error("FAIL %s: observed=\"%s\" expected=\"%s\"", tag, got, exp);
      end
   endtask

   task automatic send_rx(input string s);
      for (int i = 0; i < s.len(); i++) begin
         @(posedge clk); #1;
         bus.char_in       = s[i];
         bus.char_in_valid = 1'b1;
      end
      @(posedge clk); #1;
      bus.char_in_valid = 1'b0;
   endtask

   task automatic push_move(input logic [14:0] m);
      @(posedge clk); #1;
      bus.move_in       = m;
      bus.move_in_valid = 1'b1;
      @(negedge clk);
      chk("move_ready", 32'(bus.move_in_ready), 1);
      @(posedge clk); #1;
      bus.move_in_valid = 1'b0;
   endtask

   task automatic do_go();
      @(posedge clk); #1;
      bus.go_in_valid = 1'b1;
      @(negedge clk);
      chk("go_ready_idle", 32'(bus.go_in_ready), 1);
      @(posedge clk); #1;
      bus.go_in_valid = 1'b0;
   endtask

   task automatic take_bm(input string tag, input logic [14:0] exp);
      @(negedge clk);
      chk({tag, "_valid"}, 32'(bus.best_move_out_valid), 1);
      chk({tag, "_move"}, 32'(bm_vec), 32'(exp));
      @(posedge clk); #1;
      bus.best_move_out_ready = 1'b1;
      @(posedge clk); #1;
      bus.best_move_out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_cleared"}, 32'(bus.best_move_out_valid), 0);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.move_in             = '0;
      bus.move_in_valid       = 1'b0;
      bus.new_game_in         = 1'b0;
      bus.go_in_valid         = 1'b0;
      bus.char_out_ready      = 1'b1;
      bus.char_in             = '0;
      bus.char_in_valid       = 1'b0;
      bus.best_move_out_ready = 1'b0;

      // Reset state
      idle_cycles(3);
      @(negedge clk);
      chk("rst_ply", 32'(bus.ply_out), 0);
      chk("rst_tx_valid", 32'(bus.char_out_valid), 0);
      chk("rst_bm_valid", 32'(bus.best_move_out_valid), 0);
      chk("rst_uci_ok", 32'(bus.uci_ok_out), 0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Startup handshake
      check_tx("tx_uci", "uci\n");
      send_rx("id name x\n");
      chk("uci_ok_early", 32'(bus.uci_ok_out), 0);
      send_rx("uciok\n");
      @(negedge clk);
      chk("uci_ok", 32'(bus.uci_ok_out), 1);
      @(negedge clk);
      chk("busy_idle", 32'(bus.busy_out), 0);

      // Search from the start position
      do_go();
      check_tx("tx_pos0", "position startpos\ngo\n");
      @(negedge clk);
      chk("go_ready_wait", 32'(bus.go_in_ready), 0);
      send_rx("bestmove e2e4\n");
      take_bm("bm_e2e4", mk(4, 1, 4, 3, 0));
      chk("ply_after_bm0", 32'(bus.ply_out), 1);

      // New game clears history
      @(posedge clk); #1;
      bus.new_game_in = 1'b1;
      @(posedge clk); #1;
      bus.new_game_in = 1'b0;
      @(negedge clk);
      chk("ply_new_game", 32'(bus.ply_out), 0);

      // Two GUI moves, then search with info noise
      push_move(mk(4, 1, 4, 3, 0));
      push_move(mk(6, 7, 5, 5, 0));
      @(negedge clk);
      chk("ply_two", 32'(bus.ply_out), 2);
      do_go();
      check_tx("tx_pos2", "position startpos moves e2e4 g8f6\ngo\n");
      send_rx("info depth 3\n");
      @(negedge clk);
      chk("info_no_bm", 32'(bus.best_move_out_valid), 0);
      send_rx("bestmove d2d4\n");
      take_bm("bm_d2d4", mk(3, 1, 3, 3, 0));
      chk("ply_three", 32'(bus.ply_out), 3);

      // Promotion reply, overlong line truncated
      do_go();
      check_tx("tx_pos3", "position startpos moves e2e4 g8f6 d2d4\ngo\n");
      send_rx("bestmove e7e8q ponder e2e4\n");
      take_bm("bm_e7e8q", mk(4, 6, 4, 7, 4));
      chk("ply_full", 32'(bus.ply_out), 4);
      @(negedge clk);
      chk("move_ready_full", 32'(bus.move_in_ready), 0);

      // bestmove outside WAIT_BM is ignored
      send_rx("bestmove b1c3\n");
      idle_cycles(2);
      @(negedge clk);
      chk("bm_in_idle", 32'(bus.best_move_out_valid), 0);

      // Back-pressured TX stream with promotion char
      rand_rdy = 1'b1;
      do_go();
      check_tx("tx_pos4_rand", "position startpos moves e2e4 g8f6 d2d4 e7e8q\ngo\n");
      rand_rdy = 1'b0;
      idle_cycles(4);
      chk("tx_no_extra", 32'(txq.size()), 0);

      // Invalid bestmove is discarded; a valid one then completes
      send_rx("bestmove (none)\n");
      idle_cycles(3);
      @(negedge clk);
      chk("bm_none", 32'(bus.best_move_out_valid), 0);
      chk("go_ready_none", 32'(bus.go_in_ready), 0);
      send_rx("bestmove a7a8n\r\n");
      take_bm("bm_a7a8n", mk(0, 6, 0, 7, 1));
      chk("ply_capped", 32'(bus.ply_out), 4);

      // Reset mid-"position" with a partial RX line pending
      do_go();
      check_tx("tx_partial", "posit");
      send_rx("uc");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      txq.delete();
      @(negedge clk);
      chk("rst2_ply", 32'(bus.ply_out), 0);
      chk("rst2_uci_ok", 32'(bus.uci_ok_out), 0);
      chk("rst2_tx_valid", 32'(bus.char_out_valid), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      check_tx("tx_uci_again", "uci\n");
      send_rx("iok\n");
      @(negedge clk);
      chk("rx_abandoned", 32'(bus.uci_ok_out), 0);
      send_rx("uciok\n");
      @(negedge clk);
      @(negedge clk);
      chk("uci_ok_again", 32'(bus.uci_ok_out), 1);
      chk("busy_idle_again", 32'(bus.busy_out), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
